// File: rtl/avst_video_pkg.sv
// Shared Avalon-ST video definitions.
// Packet type, pattern and FSM encodings, RGB888 packing.
package avst_video_pkg;

  localparam logic [3:0] VID_PKT_TYPE_VIDEO = 4'h0;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_BARS  = 2'd2,
    PAT_COUNT = 2'd3
  } pat_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_PIXELS = 2'd2
  } state_e;

  function automatic logic [23:0] rgb888(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return {r, g, b};
  endfunction

endpackage

// File: rtl/avst_pattern_gen.sv
// Combinational test-pattern pixel generator.
// Maps raster position and pattern select to one RGB beat.
module avst_pattern_gen
  import avst_video_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int DATA_W = 24,
  parameter int XW     = 9,
  parameter int YW     = 8
) (
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  input  logic [DATA_W-1:0] idx,
  input  pat_e              pattern,
  input  logic [DATA_W-1:0] color,
  output logic [DATA_W-1:0] pixel
);

  logic [7:0] x8;
  logic [7:0] y8;
  logic [2:0] bar;

  // select the pixel value for the current pattern
  always_comb begin
    x8    = 8'(x);
    y8    = 8'(y);
    bar   = 3'((32'(x) << 3) / WIDTH);
    pixel = '0;
    unique case (pattern)
      PAT_SOLID: pixel = color;
      PAT_GRAD:  pixel = DATA_W'(rgb888(x8, y8, x8 ^ y8));
      PAT_BARS:  pixel = DATA_W'(rgb888(
                   {8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}));
      PAT_COUNT: pixel = idx;
      default:   pixel = '0;
    endcase
  end

endmodule

// File: rtl/avst_rgb_frame_source.sv
// Avalon-ST video frame source: header beat then a raster of pixels.
// Registered outputs, holds beats under backpressure, optional re-arm.
module avst_rgb_frame_source
  import avst_video_pkg::*;
#(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int DATA_W  = 24,
  parameter int EMPTY_W = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_start,
  input  logic               cfg_continuous,
  input  logic [1:0]         cfg_pattern,
  input  logic [DATA_W-1:0]  cfg_color,
  output logic               busy,
  output logic               frame_done,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  state_e              state;
  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic [DATA_W-1:0]   idx;
  pat_e                pat_q;
  logic [DATA_W-1:0]   color_q;
  logic [XW-1:0]       nx;
  logic [YW-1:0]       ny;
  logic [DATA_W-1:0]   nidx;
  logic                last;
  logic                nlast;
  logic                fire;
  logic [DATA_W-1:0]   pix;

  assign out_empty = '0;
  assign fire      = out_valid & out_ready;

  // position of the pixel that follows the beat now on the bus
  always_comb begin
    nx   = '0;
    ny   = '0;
    nidx = '0;
    if (state == ST_PIXELS) begin
      if (x == X_LAST) begin
        nx = '0;
        ny = y + 1'b1;
      end else begin
        nx = x + 1'b1;
        ny = y;
      end
      nidx = idx + 1'b1;
    end
    last  = (x == X_LAST) && (y == Y_LAST);
    nlast = (nx == X_LAST) && (ny == Y_LAST);
  end

  avst_pattern_gen #(
    .WIDTH  (WIDTH),
    .DATA_W (DATA_W),
    .XW     (XW),
    .YW     (YW)
  ) u_gen (
    .x       (nx),
    .y       (ny),
    .idx     (nidx),
    .pattern (pat_q),
    .color   (color_q),
    .pixel   (pix)
  );

  // frame FSM, raster counters and the output register stage
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= ST_IDLE;
      x                 <= '0;
      y                 <= '0;
      idx               <= '0;
      pat_q             <= PAT_SOLID;
      color_q           <= '0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      out_valid         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_data          <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            state             <= ST_HEADER;
            pat_q             <= pat_e'(cfg_pattern);
            color_q           <= cfg_color;
            busy              <= 1'b1;
            out_valid         <= 1'b1;
            out_startofpacket <= 1'b1;
            out_endofpacket   <= 1'b0;
            out_data          <= DATA_W'(VID_PKT_TYPE_VIDEO);
          end
        end
        ST_HEADER: begin
          if (fire) begin
            state             <= ST_PIXELS;
            x                 <= '0;
            y                 <= '0;
            idx               <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= nlast;
            out_data          <= pix;
          end
        end
        ST_PIXELS: begin
          if (fire) begin
            if (last) begin
              frame_done      <= 1'b1;
              x               <= '0;
              y               <= '0;
              idx             <= '0;
              out_endofpacket <= 1'b0;
              if (cfg_continuous) begin
                state             <= ST_HEADER;
                pat_q             <= pat_e'(cfg_pattern);
                color_q           <= cfg_color;
                out_startofpacket <= 1'b1;
                out_data          <= DATA_W'(VID_PKT_TYPE_VIDEO);
              end else begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                out_data  <= '0;
              end
            end else begin
              x               <= nx;
              y               <= ny;
              idx             <= nidx;
              out_endofpacket <= nlast;
              out_data        <= pix;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avst_rgb_frame_source.sv
// Bench for avst_rgb_frame_source: 4x2 and 8x2 instances.
// Accepted beats are compared against a raster reference model.
module tb_avst_rgb_frame_source;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1;
  logic        start4 = 1'b0;
  logic        start8 = 1'b0;
  logic        cont = 1'b0;
  logic        ready = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic [23:0] color = 24'd0;

  logic        busy4, fd4, s4, e4, v4;
  logic [23:0] d4;
  logic [1:0]  em4;
  logic        busy8, fd8, s8, e8, v8;
  logic [23:0] d8;
  logic [1:0]  em8;

  avst_rgb_frame_source #(.WIDTH(4), .HEIGHT(2)) u4 (
    .clock(clock), .reset(reset), .cfg_start(start4),
    .cfg_continuous(cont), .cfg_pattern(pattern), .cfg_color(color),
    .busy(busy4), .frame_done(fd4), .out_data(d4),
    .out_startofpacket(s4), .out_endofpacket(e4), .out_empty(em4),
    .out_valid(v4), .out_ready(ready)
  );

  avst_rgb_frame_source #(.WIDTH(8), .HEIGHT(2)) u8 (
    .clock(clock), .reset(reset), .cfg_start(start8),
    .cfg_continuous(cont), .cfg_pattern(pattern), .cfg_color(color),
    .busy(busy8), .frame_done(fd8), .out_data(d8),
    .out_startofpacket(s8), .out_endofpacket(e8), .out_empty(em8),
    .out_valid(v8), .out_ready(ready)
  );

  typedef struct packed {
    logic        s;
    logic        e;
    logic [23:0] d;
  } beat_t;

  beat_t cap4[$];
  beat_t cap8[$];
  int    st4[$];
  int    st8[$];
  int    fs4[$];
  int    fs8[$];
  int    cyc = 0;
  int    total = 0;
  int    passed = 0;
  bit    hold4 = 1'b0;
  bit    hold8 = 1'b0;
  logic [26:0] prev4, prev8;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [23:0] ref_pix(input int w, input int idx,
                                          input int pat,
                                          input logic [23:0] col);
    int x, y, b;
    logic [7:0] xl, yl;
    x  = idx % w;
    y  = idx / w;
    xl = 8'(x);
    yl = 8'(y);
    b  = (x * 8) / w;
    case (pat)
      0: return col;
      1: return {xl, yl, xl ^ yl};
      2: return {b[2] ? 8'hFF : 8'h00, b[1] ? 8'hFF : 8'h00,
                 b[0] ? 8'hFF : 8'h00};
      default: return 24'(idx);
    endcase
  endfunction

  task automatic clr();
    cap4.delete(); cap8.delete();
    st4.delete(); st8.delete();
    fs4.delete(); fs8.delete();
  endtask

  task automatic tick(input bit rdy);
    logic [26:0] c4, c8;
    c4 = {v4, s4, e4, d4};
    c8 = {v8, s8, e8, d8};
    if (hold4) chk("hold4", 32'(c4), 32'(prev4));
    if (hold8) chk("hold8", 32'(c8), 32'(prev8));
    ready = rdy;
    hold4 = v4 && !rdy;
    hold8 = v8 && !rdy;
    prev4 = c4;
    prev8 = c8;
    if (v4 && rdy) begin
      cap4.push_back({s4, e4, d4});
      st4.push_back(cyc);
    end
    if (v8 && rdy) begin
      cap8.push_back({s8, e8, d8});
      st8.push_back(cyc);
    end
    if (fd4) fs4.push_back(cyc);
    if (fd8) fs8.push_back(cyc);
    @(negedge clock);
    cyc++;
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic run_idle(input int mode, input string tag);
    int n;
    bit r;
    n = 0;
    while ((busy4 || busy8) && n < 4000) begin
      case (mode)
        0: r = 1'b1;
        1: r = (n % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      tick(r);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy4 | busy8), 32'd0);
    tick(1'b1);
  endtask

  task automatic check_frame(input string tag, input int which,
                             input int w, input int h, input int pat,
                             input logic [23:0] col);
    int n, avail;
    beat_t b, e;
    n = w * h + 1;
    avail = (which == 4) ? cap4.size() : cap8.size();
    chk({tag, "_len"}, 32'(avail >= n), 32'd1);
    if (avail >= n) begin
      for (int i = 0; i < n; i++) begin
        if (which == 4) b = cap4.pop_front();
        else b = cap8.pop_front();
        e.s = (i == 0);
        e.e = (i == n - 1);
        e.d = (i == 0) ? 24'h0 : ref_pix(w, i - 1, pat, col);
        chk($sformatf("%s_b%0d", tag, i), 32'(b), 32'(e));
      end
    end
  endtask

  initial begin
    int n;
    logic [23:0] c;
    int p;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_valid", 32'({v4, v8}), 32'd0);
    chk("rst_sop_eop", 32'({s4, e4, s8, e8}), 32'd0);
    chk("rst_busy_done", 32'({busy4, fd4, busy8, fd8}), 32'd0);
    chk("rst_data", 32'(d4 | d8), 32'd0);
    chk("rst_empty", 32'({em4, em8}), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1: full throughput, counter pattern
    clr();
    pattern = 2'd3;
    start4 = 1'b1;
    tick(1'b1);
    chk("t1_lat_valid", 32'(v4), 32'd1);
    chk("t1_lat_sop", 32'(s4), 32'd1);
    chk("t1_busy", 32'(busy4), 32'd1);
    run_idle(0, "t1");
    chk("t1_nbeats", 32'(st4.size()), 32'd9);
    chk("t1_consec", 32'(st4[$] - st4[0]), 32'd8);
    chk("t1_ndone", 32'(fs4.size()), 32'd1);
    chk("t1_done_at", 32'(fs4[0]), 32'(st4[$] + 1));
    check_frame("t1", 4, 4, 2, 3, 24'h0);

    // 2: ready toggling every cycle
    clr();
    start4 = 1'b1;
    tick(1'b1);
    run_idle(1, "t2");
    check_frame("t2", 4, 4, 2, 3, 24'h0);
    chk("t2_extra", 32'(cap4.size()), 32'd0);
    chk("t2_ndone", 32'(fs4.size()), 32'd1);

    // 3: continuous mode for three frames
    clr();
    cont = 1'b1;
    start4 = 1'b1;
    tick(1'b1);
    n = 0;
    while (busy4 && n < 300) begin
      if (fs4.size() >= 2) cont = 1'b0;
      tick(1'b1);
      n++;
    end
    chk("t3_idle", 32'(busy4), 32'd0);
    tick(1'b1);
    cont = 1'b0;
    chk("t3_nbeats", 32'(st4.size()), 32'd27);
    chk("t3_consec", 32'(st4[$] - st4[0]), 32'd26);
    chk("t3_ndone", 32'(fs4.size()), 32'd3);
    check_frame("t3f0", 4, 4, 2, 3, 24'h0);
    check_frame("t3f1", 4, 4, 2, 3, 24'h0);
    check_frame("t3f2", 4, 4, 2, 3, 24'h0);

    // 4: reset while pixel beat 3 is presented
    clr();
    start4 = 1'b1;
    tick(1'b1);
    n = 0;
    while (cap4.size() < 4 && n < 50) begin
      tick(1'b1);
      n++;
    end
    chk("t4_pre_valid", 32'(v4), 32'd1);
    chk("t4_pre_data", 32'(d4), 32'd3);
    foreach (cap4[i]) chk($sformatf("t4_noeop%0d", i), 32'(cap4[i].e), 32'd0);
    reset = 1'b1;
    tick(1'b0);
    chk("t4_valid", 32'(v4), 32'd0);
    chk("t4_eop", 32'(e4), 32'd0);
    chk("t4_busy", 32'(busy4), 32'd0);
    chk("t4_data", 32'(d4), 32'd0);
    reset = 1'b0;
    hold4 = 1'b0;
    hold8 = 1'b0;
    tick(1'b1);
    chk("t4_nodone", 32'(fs4.size()), 32'd0);
    clr();
    start4 = 1'b1;
    tick(1'b1);
    run_idle(2, "t4");
    check_frame("t4", 4, 4, 2, 3, 24'h0);

    // 5: mid-frame start and pattern change are ignored
    clr();
    pattern = 2'd2;
    color = 24'($urandom);
    start8 = 1'b1;
    tick(1'b1);
    n = 0;
    while (cap8.size() < 6 && n < 200) begin
      tick(1'($urandom_range(0, 1)));
      n++;
    end
    pattern = 2'd3;
    start8 = 1'b1;
    run_idle(2, "t5");
    check_frame("t5", 8, 8, 2, 2, 24'h0);
    chk("t5_extra", 32'(cap8.size()), 32'd0);
    chk("t5_ndone", 32'(fs8.size()), 32'd1);

    // randomized frames on both instances
    for (int k = 0; k < 4; k++) begin
      clr();
      p = int'($urandom_range(0, 3));
      c = 24'($urandom);
      pattern = 2'(p);
      color = c;
      start4 = 1'b1;
      start8 = 1'b1;
      tick(1'b1);
      run_idle(2, $sformatf("r%0d", k));
      check_frame($sformatf("r%0d_u4", k), 4, 4, 2, p, c);
      check_frame($sformatf("r%0d_u8", k), 8, 8, 2, p, c);
      chk($sformatf("r%0d_done", k), 32'({fs4.size() == 1, fs8.size() == 1}),
          32'd3);
      chk($sformatf("r%0d_empty", k), 32'({em4, em8}), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
